// File: rtl/mem_access_pkg.sv
// Shared constants and types for the memory-stage load/store unit.
// The MISALIGN_TRAP_EN build option is resolved in memory_access_unit.
package mem_access_pkg;

  localparam int ADDR_W_DEF = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_byte(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface memory_access_unit_if #(
  parameter int ADDR_W = mem_access_pkg::ADDR_W_DEF
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              ready;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/load_formatter.sv
// Selects the addressed lane of a read word and sign/zero-extends it per funct3.
module load_formatter
  import mem_access_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    // halfword lane uses addr[1] only; addr[0] is either trapped or ignored upstream
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: one bus transaction per load/store, global stall until done.
// Build option MISALIGN_TRAP_EN: kill misaligned halfword/word accesses and raise misalign.
module memory_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemReadM,
  input  logic                MemWriteM,
  input  logic [2:0]          funct3M,
  input  logic [ADDR_W-1:0]   ALUResultM,
  input  logic [31:0]         WriteDataM,
  output logic [31:0]         ReadDataM,
  output logic                stall,
  output logic                misalign,
  memory_access_unit_if.master dmem
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_rdata;
  logic        w_mem;
  logic        w_kill;
  logic        w_access;
  logic        w_req;
  logic        w_capture;
  logic [1:0]  w_lo;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_fmt;

  assign w_mem = MemReadM | MemWriteM;
  assign w_lo  = ALUResultM[1:0];

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    w_kill = 1'b0;
    if (w_mem) begin
      if (is_byte(funct3M))      w_kill = 1'b0;
      else if (is_half(funct3M)) w_kill = w_lo[0];
      else                       w_kill = |w_lo;
    end
  end
`else
  assign w_kill = 1'b0;
`endif

  assign w_access = w_mem & ~w_kill;

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = WriteDataM;
    if (MemWriteM) begin
      case (funct3M)
        F3_B: begin
          w_wstrb = 4'b0001 << w_lo;
          w_wdata = {4{WriteDataM[7:0]}};
        end
        F3_H: begin
          w_wstrb = w_lo[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{WriteDataM[15:0]}};
        end
        default: w_wstrb = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // DONE is the single cycle the instruction sits unstalled before leaving MEM
  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          w_req  = 1'b1;
          w_next = dmem.ready ? DONE : BUSY;
        end
      end
      BUSY: begin
        w_req = 1'b1;
        if (dmem.ready) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  load_formatter u_fmt (
    .i_funct3  (funct3M),
    .i_addr_lo (w_lo),
    .i_rdata   (dmem.rdata),
    .o_data    (w_fmt)
  );

  assign w_capture = w_req & dmem.ready & ~MemWriteM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_rdata <= '0;
    else if (w_capture) r_rdata <= w_fmt;
  end

  assign ReadDataM  = r_rdata;
  assign stall      = w_req & ~rst;
  assign misalign   = w_kill & (r_state == IDLE) & ~rst;
  assign dmem.req   = w_req & ~rst;
  assign dmem.we    = MemWriteM;
  assign dmem.addr  = {ALUResultM[ADDR_W-1:2], 2'b00};
  assign dmem.wdata = w_wdata;
  assign dmem.wstrb = w_wstrb;

endmodule

// File: tb/tb_memory_access_unit.sv
// Randomized bench for memory_access_unit against a transaction-level model of the load/store rules.
module tb_memory_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        stall, misalign;

  int vectors = 0;
  int miscompares = 0;
  int stall_seen = 0;

  logic        exp_req, exp_stall, exp_mis, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rd;
  logic [3:0]  exp_wstrb;
  logic [31:0] model_rd;

  always #5 clk = ~clk;

  memory_access_unit_if #(.ADDR_W(32)) bus ();

  memory_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .stall      (stall),
    .misalign   (misalign),
    .dmem       (bus.master)
  );

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == F3_B || f3 == F3_BU) return 1;
    if (f3 == F3_H || f3 == F3_HU) return 2;
    return 4;
  endfunction

  function automatic logic m_kill(input int kind, input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (kind != 0) && ((int'(a[1:0]) % size_of(f3)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * int'(a[1:0])));
    h = 16'(w >> (16 * int'(a[1])));
    case (f3)
      F3_B:    return 32'(signed'(b));
      F3_BU:   return 32'(b);
      F3_H:    return 32'(signed'(h));
      F3_HU:   return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input int kind, input logic [2:0] f3, input logic [31:0] a);
    if (kind != 2) return 4'b0000;
    if (f3 == F3_B) return 4'(1 << int'(a[1:0]));
    if (f3 == F3_H) return 4'(3 << int'(a[1:0] & 2'b10));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (f3 == F3_B) return 32'(w[7:0]) * 32'h0101_0101;
    if (f3 == F3_H) return 32'(w[15:0]) * 32'h0001_0001;
    return w;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("req", 32'(bus.req), 32'(exp_req));
    chk("misalign", 32'(misalign), 32'(exp_mis));
    chk("ReadDataM", ReadDataM, exp_rd);
    if (stall === 1'b1) stall_seen++;
    if (exp_req) begin
      chk("we", 32'(bus.we), 32'(exp_we));
      chk("addr", bus.addr, exp_addr);
      chk("wstrb", 32'(bus.wstrb), 32'(exp_wstrb));
      chk("wdata", bus.wdata, exp_wdata);
    end
  endtask

  task automatic set_inputs(input int kind, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    MemReadM   = (kind == 1);
    MemWriteM  = (kind == 2);
    funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
  endtask

  // Apply one instruction in MEM, holding it for as long as the model says it stalls.
  task automatic run_instr(input int kind, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int waits);
    logic kill;
    kill = m_kill(kind, f3, a);
    exp_we    = (kind == 2);
    exp_addr  = a & 32'hFFFF_FFFC;
    exp_wstrb = m_strb(kind, f3, a);
    exp_wdata = (kind == 2) ? m_wdata(f3, wd) : wd;
    if (kind != 0 && !kill) begin
      for (int k = 0; k <= waits; k++) begin
        @(negedge clk);
        set_inputs(kind, f3, a, wd);
        bus.ready = (k == waits);
        bus.rdata = (k == waits) ? rd : $urandom;
        exp_req = 1'b1; exp_stall = 1'b1; exp_mis = 1'b0; exp_rd = model_rd;
        #2 compare_outputs();
      end
      if (kind == 1) model_rd = m_load(f3, a, rd);
      @(negedge clk);
      bus.ready = 1'($urandom_range(0, 1));
      bus.rdata = $urandom;
      exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_rd = model_rd;
      #2 compare_outputs();
    end else begin
      @(negedge clk);
      set_inputs(kind, f3, a, wd);
      bus.ready = 1'($urandom_range(0, 1));
      bus.rdata = $urandom;
      exp_req = 1'b0; exp_stall = 1'b0; exp_mis = kill; exp_rd = model_rd;
      #2 compare_outputs();
    end
  endtask

  initial begin
    int s0;
    int kind, waits, r;
    logic [2:0] f3;

    model_rd = '0;
    rst = 1'b1;
    bus.ready = 1'b0;
    bus.rdata = '0;
    set_inputs(1, F3_W, 32'h100, 32'h0);

    // reset state with a load already presented
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    @(negedge clk);
    set_inputs(0, F3_W, 32'h0, 32'h0);
    rst = 1'b0;

    // model pins
    chk("pin_lb", m_load(F3_B, 32'h103, 32'h8011_2233), 32'hFFFF_FF80);
    chk("pin_lbu", m_load(F3_BU, 32'h103, 32'h8011_2233), 32'h0000_0080);
    chk("pin_sh_strb", 32'(m_strb(2, F3_H, 32'h202)), 32'h0000_000C);
    chk("pin_sh_wdata", m_wdata(F3_H, 32'h0000_ABCD), 32'hABCD_ABCD);
`ifdef MISALIGN_TRAP_EN
    chk("pin_lw_mis", 32'(m_kill(1, F3_W, 32'h101)), 32'd1);
`else
    chk("pin_lw_mis", 32'(m_kill(1, F3_W, 32'h101)), 32'd0);
`endif

    // LW, ready in request cycle
    s0 = stall_seen;
    run_instr(1, F3_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    chk("lw_stall_cycles", 32'(stall_seen - s0), 32'd1);
    chk("lw_data", ReadDataM, 32'hDEAD_BEEF);

    // LB / LBU with three wait cycles
    s0 = stall_seen;
    run_instr(1, F3_B, 32'h103, 32'h0, 32'h8011_2233, 3);
    chk("lb_stall_cycles", 32'(stall_seen - s0), 32'd4);
    chk("lb_data", ReadDataM, 32'hFFFF_FF80);
    run_instr(1, F3_BU, 32'h103, 32'h0, 32'h8011_2233, 3);
    chk("lbu_data", ReadDataM, 32'h0000_0080);

    // SH, then a non-memory instruction
    run_instr(2, F3_H, 32'h202, 32'h0000_ABCD, 32'h0, 0);
    chk("sh_keeps_rdata", ReadDataM, 32'h0000_0080);
    s0 = stall_seen;
    run_instr(0, F3_W, 32'h0, 32'h0, 32'h0, 0);
    chk("nonmem_stall", 32'(stall_seen - s0), 32'd0);

    // back-to-back SW then LW
    s0 = stall_seen;
    run_instr(2, F3_W, 32'h300, 32'h1234_5678, 32'h0, 1);
    run_instr(1, F3_W, 32'h300, 32'h0, 32'h1234_5678, 0);
    chk("b2b_stall_cycles", 32'(stall_seen - s0), 32'd3);
    chk("b2b_lw_data", ReadDataM, 32'h1234_5678);

    // LW at 0x101
    run_instr(1, F3_W, 32'h101, 32'h0, 32'hCAFE_F00D, 0);
`ifndef MISALIGN_TRAP_EN
    chk("lw_unaligned_data", ReadDataM, 32'hCAFE_F00D);
`endif

    // reset while BUSY
    @(negedge clk);
    set_inputs(1, F3_W, 32'h140, 32'h0);
    bus.ready = 1'b0;
    exp_req = 1'b1; exp_stall = 1'b1; exp_mis = 1'b0; exp_rd = model_rd;
    exp_we = 1'b0; exp_addr = 32'h140; exp_wstrb = 4'b0000; exp_wdata = 32'h0;
    #2 compare_outputs();
    @(negedge clk);
    #2 compare_outputs();
    #1 rst = 1'b1;
    #1;
    chk("rst_busy_req", 32'(bus.req), 32'd0);
    chk("rst_busy_stall", 32'(stall), 32'd0);
    chk("rst_busy_rdata", ReadDataM, 32'd0);
    @(negedge clk);
    set_inputs(0, F3_W, 32'h0, 32'h0);
    rst = 1'b0;
    model_rd = '0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 2) begin
        r  = $urandom_range(0, 9);
        f3 = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      waits = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 4);
      run_instr(kind, f3, 32'h1000 + 32'($urandom_range(0, 63)), $urandom, $urandom, waits);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory-stage load/store unit of the pipelined RISC-V core. Sits between the EX/MEM pipeline register and the data-memory bus. It turns MemReadM/MemWriteM into a single ready/request bus transaction, formats store data and byte strobes, extracts and sign-extends load data into ReadDataM, and drives the global stall that holds every pipeline register, including memory→writeback, until the access completes.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of the data bus

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- MemReadM  in  1  load in memory stage
- MemWriteM  in  1  store in memory stage
- funct3M  in  3  access size/sign (RV32I load/store encoding)
- ALUResultM  in  ADDR_W  effective byte address
- WriteDataM  in  32  store source register value
- ReadDataM  out  32  formatted load result, to memory→writeback register
- stall  out  1  hold all pipeline registers this cycle
- misalign  out  1  misaligned access flag (see Configuration)
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte-lane write enables
- dmem_ready  in  1  transaction complete; rdata valid when read
- dmem_rdata  in  32  read word

## Operation
- States: IDLE, BUSY, DONE.
- access = (MemReadM | MemWriteM) & ~misaligned_kill.
- IDLE: if access, dmem_req=1 combinationally; dmem_ready=1 → DONE; else → BUSY.
- BUSY: dmem_req=1; stay until dmem_ready=1, then → DONE.
- DONE: dmem_req=0; always → IDLE (the instruction leaves MEM on this edge).
- stall = (IDLE & access) | BUSY; forced 0 while rst=1.
- Bus request fields (addr, we, wdata, wstrb) derive from the held MEM inputs and stay stable while req=1. dmem_ready is ignored when req=0.
- Stores:
  - SB: wstrb = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: wstrb = 0011 << {addr[1],0}; wdata = half replicated x2.
  - SW: wstrb = 1111.
  - Loads drive wstrb = 0000.
- Loads: when dmem_ready & ~we, capture the formatted word into the ReadDataM register.
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend.
  - LW: pass through.
  - Unknown funct3: treat as word.
- Stores and non-memory instructions leave ReadDataM unchanged.
- Reset mid-transaction: state → IDLE, ReadDataM → 0, req drops immediately; the bus must tolerate abandoned requests.

## Timing
- Reset values: ReadDataM=0, state=IDLE, dmem_req=0, stall=0, misalign=0.
- Non-memory instruction: 0 stall cycles.
- Memory access with ready in the request cycle: 1 stall cycle. Total: 2 cycles in MEM.
- Each extra wait cycle adds 1 stall cycle.
- ReadDataM is valid in DONE, which is the cycle where stall=0 and the memory→writeback register samples.
- Back-to-back memory ops: the second issues in the IDLE cycle following DONE. No bubble beyond the DONE cycle.

## Configuration
- MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, sets misaligned_kill.
  - Effect: no request, no stall, misalign=1 combinationally for that cycle, ReadDataM unchanged.
- Undefined:
  - misalign tied 0.
  - Halfword accesses ignore addr[0].
  - Word accesses ignore addr[1:0] (forced aligned).

## Structure
- Package mem_access_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state enum (IDLE, BUSY, DONE).
  - ADDR_W default.
- Sub-module load_formatter: combinational lane select plus sign/zero extension from {funct3, addr[1:0], rdata}. Shared with any future load path.

## Test plan
- Reset while BUSY (req=1): assert rst → req=0, stall=0, ReadDataM=0 asynchronously. Release → IDLE.
- LW addr 0x100, ready in request cycle, rdata 0xDEADBEEF → stall high 1 cycle, then ReadDataM=0xDEADBEEF with stall=0.
- LB addr 0x103, rdata 0x80112233, ready after 3 wait cycles → stall high 4 cycles, ReadDataM=0xFFFFFF80. LBU same → 0x00000080.
- SH addr 0x202, data 0x0000ABCD → dmem_addr=0x200, wstrb=1100, wdata=0xABCDABCD, we=1.
- Non-memory instruction following a store → stall=0, no req. Back-to-back SW then LW → two distinct transactions, one DONE cycle between them.
- LW addr 0x101:
  - with MISALIGN_TRAP_EN → misalign=1, req=0, stall=0.
  - without → dmem_addr=0x100, normal load.
